// File: rtl/jk_seq_driver.sv
// jk_seq_driver: queued J/K command sequencer for a downstream JK flip-flop.
// Commands are buffered, each driven for REP+1 cycles, with Q tracked locally.
module jk_seq_driver #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] cmd,
    input  logic [3:0] rep,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic       j,
    output logic       k,
    output logic       busy,
    output logic       q_exp
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic [1:0] cmd;
        logic [3:0] rep;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [3:0]    rcnt;
    logic [3:0]    rcnt_nx;
    logic          j_nx;
    logic          k_nx;
    logic          q_nx;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          rcnt_zero;
    state_t        state;
    state_t        state_nx;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign cmd_ready = rst_n & ~full;
    assign push      = cmd_valid & cmd_ready;
    assign head      = mem[rd_ptr];
    assign rcnt_zero = (rcnt == 4'd0);
    assign busy      = (state == DRIVE);

    // The head leaves the queue when nothing is being driven or the
    // current command is on its last cycle.
    assign pop = ~empty & ((state == IDLE) | rcnt_zero);

    // Command storage; occupancy is tracked by count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{cmd: cmd, rep: rep};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state: leave IDLE on any queued entry, return when drained.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    state_nx = DRIVE;
                end
            end
            DRIVE: begin
                if (rcnt_zero && empty) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs: next J/K drive and remaining-cycle count.
    always_comb begin
        j_nx    = j;
        k_nx    = k;
        rcnt_nx = rcnt;
        unique case (1'b1)
            pop: begin
                j_nx    = head.cmd[1];
                k_nx    = head.cmd[0];
                rcnt_nx = head.rep;
            end
            (busy && !rcnt_zero): begin
                rcnt_nx = rcnt - 4'd1;
            end
            default: begin
                j_nx    = 1'b0;
                k_nx    = 1'b0;
                rcnt_nx = 4'd0;
            end
        endcase
    end

    // Expected flip-flop response to the J/K currently on the wires.
    always_comb begin
        q_nx = q_exp;
        unique case ({j, k})
            2'b01:   q_nx = 1'b0;
            2'b10:   q_nx = 1'b1;
            2'b11:   q_nx = ~q_exp;
            default: q_nx = q_exp;
        endcase
    end

    // Registered drive, repeat counter and Q model.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j     <= 1'b0;
            k     <= 1'b0;
            rcnt  <= 4'd0;
            q_exp <= 1'b0;
        end else begin
            j     <= j_nx;
            k     <= k_nx;
            rcnt  <= rcnt_nx;
            q_exp <= q_nx;
        end
    end

endmodule

// File: doc/jk_seq_driver.md
JK_SEQ_DRIVER -- requirements
Module: jk_seq_driver

Interface
REQ-001 Parameter DEPTH, default 4, is the command FIFO depth in entries; legal values are powers of two from 2 to 16.
REQ-002 CLK  input  1  is the single clock; all state updates on its rising edge.
REQ-003 RST_N  input  1  is the reset; it is asynchronous and active-low.
REQ-004 CMD  input  2  is the command code: 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE.
REQ-005 REP  input  4  is the repeat field; the command is driven for REP+1 consecutive cycles (1..16).
REQ-006 CMD_VALID  input  1  means CMD/REP are offered this cycle.
REQ-007 CMD_READY  output  1  means the FIFO can accept an entry this cycle.
REQ-008 J  output  1  is the registered J drive to the downstream JK flip-flop.
REQ-009 K  output  1  is the registered K drive to the downstream JK flip-flop.
REQ-010 BUSY  output  1  is high while a command is being driven (state DRIVE).
REQ-011 Q_EXP  output  1  is the registered model of the expected flip-flop Q.

Function
REQ-012 A command SHALL be written into the FIFO at a rising CLK edge where CMD_VALID=1 and CMD_READY=1; otherwise the FIFO SHALL be left unchanged.
REQ-013 CMD_READY SHALL be 1 exactly when the FIFO holds fewer than DEPTH entries and RST_N=1; a full FIFO SHALL refuse writes even if a pop occurs in the same cycle.
REQ-014 The FSM SHALL have two states: IDLE (J=0, K=0, BUSY=0) and DRIVE (J/K from the current command, BUSY=1).
REQ-015 IDLE -> DRIVE SHALL occur at the first edge where the FIFO is non-empty; that edge pops the head, loads J/K per the encoding (HOLD 0/0, RESET 0/1, SET 1/0, TOGGLE 1/1), and loads the remaining-count register RCNT=REP.
REQ-016 Latency: a command written at edge t into an empty FIFO in IDLE SHALL appear on J/K after edge t+1; a direct same-edge bypass is not permitted.
REQ-017 In DRIVE, an edge with RCNT>0 SHALL decrement RCNT and hold J/K.
REQ-018 In DRIVE, an edge with RCNT=0 SHALL either pop and load the next command with no gap cycle when the FIFO is non-empty, or return to IDLE with J=K=0 when it is empty.
REQ-019 A simultaneous write and pop SHALL leave the FIFO occupancy unchanged; the read and write pointers SHALL wrap modulo DEPTH.
REQ-020 Q_EXP SHALL update at every edge from the J/K values present before that edge: 00 hold, 01 -> 0, 10 -> 1, 11 -> invert.
REQ-021 J and K SHALL never change other than at a rising CLK edge or on reset assertion.

Reset
REQ-022 While RST_N=0, the block SHALL force: FIFO empty, state IDLE, RCNT=0, J=0, K=0, BUSY=0, Q_EXP=0, CMD_READY=0.
REQ-023 Reset assertion mid-DRIVE SHALL discard the current command and all queued entries immediately, without waiting for a clock edge.
REQ-024 After RST_N deasserts, the first edge SHALL be able to accept a command, and CMD_READY=1.

Verification
REQ-025 Single command: write CMD=10, REP=0 into an idle block -> J=1, K=0, BUSY=1 for exactly 1 cycle starting one cycle after the write; Q_EXP=1 one edge later; then J=K=0 and BUSY=0.
REQ-026 Back-to-back: write RESET/REP=1, TOGGLE/REP=2, HOLD/REP=0 on consecutive cycles -> J/K sequence 01,01,11,11,11,00 with no gap; Q_EXP sequence 0,0,1,0,1 held.
REQ-027 Full FIFO: with DEPTH=4 and DRIVE stuck on REP=15, write 4 commands -> CMD_READY=0 after the 4th write; a 5th CMD_VALID is ignored; CMD_READY returns to 1 the cycle after the first pop.
REQ-028 Wrap-around: stream 10 commands with CMD_VALID held high -> all 10 are driven in order and none is lost or duplicated.
REQ-029 Reset mid-operation: pull RST_N low during TOGGLE/REP=5 with 2 entries queued -> J=K=0, BUSY=0, Q_EXP=0 immediately; after release, nothing is driven until a new write.
